// File: rtl/alu_stage_ctrl.sv
// Execute-stage pipeline controller: post-reset hold, branch flush, memory stall watchdog, load-use bubble.
// Optional performance counters are built when ALU_STAGE_CTRL_PERF_EN is defined.
module alu_stage_ctrl #(
   parameter int RST_HOLD      = 2,
   parameter int FLUSH_CYCLES  = 2,
   parameter int STALL_TIMEOUT = 1024
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_dec_valid,
   input  logic [4:0]  i_dec_rs1_addr,
   input  logic [4:0]  i_dec_rs2_addr,
   input  logic        i_dec_uses_rs2,
   input  logic [4:0]  i_alu_rd_addr,
   input  logic        i_alu_wr_rd,
   input  logic        i_alu_is_load,
   input  logic        i_change_pc,
   input  logic        i_mem_stall,
   input  logic        i_force_stall,
   output logic        o_alu_ce,
   output logic        o_alu_stall,
   output logic        o_alu_flush,
   output logic        o_dec_stall,
   output logic [2:0]  o_state,
   output logic        o_timeout,
   output logic [31:0] o_perf_issued,
   output logic [31:0] o_perf_bubbles
);
   localparam logic [2:0] ST_RESET_WAIT = 3'd0;
   localparam logic [2:0] ST_RUN        = 3'd1;
   localparam logic [2:0] ST_HAZARD     = 3'd2;
   localparam logic [2:0] ST_FLUSH      = 3'd3;
   localparam logic [2:0] ST_STALL      = 3'd4;

   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int SW = $clog2(STALL_TIMEOUT + 1);
   localparam logic [HW-1:0] HOLD_INIT  = HW'(RST_HOLD - 1);
   localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_CYCLES - 1);
   localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_TIMEOUT);

   logic [2:0]    state_r, state_s;
   logic [HW-1:0] hold_cnt_r, hold_cnt_s;
   logic [FW-1:0] flush_cnt_r, flush_cnt_s;
   logic [SW-1:0] stall_cnt_r, stall_cnt_s;
   logic          flush_r, timeout_r;
   logic          hazard_s, stall_req_s;
   logic          alu_ce_s, alu_stall_s, dec_stall_s;

   // Load-use hazard is only acted on from RUN, so the held rd cannot re-trigger in HAZARD.
   assign hazard_s = i_dec_valid & i_alu_is_load & i_alu_wr_rd & (i_alu_rd_addr != 5'd0) &
                     ((i_alu_rd_addr == i_dec_rs1_addr) |
                      (i_dec_uses_rs2 & (i_alu_rd_addr == i_dec_rs2_addr))) &
                     (state_r == ST_RUN);
   assign stall_req_s = i_mem_stall | i_force_stall;

   // State and counter registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r     <= ST_RESET_WAIT;
         hold_cnt_r  <= HOLD_INIT;
         flush_cnt_r <= {FW{1'b0}};
         stall_cnt_r <= {SW{1'b0}};
         flush_r     <= 1'b0;
         timeout_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         hold_cnt_r  <= hold_cnt_s;
         flush_cnt_r <= flush_cnt_s;
         stall_cnt_r <= stall_cnt_s;
         flush_r     <= (state_s == ST_FLUSH);
         timeout_r   <= timeout_r | (stall_cnt_s == STALL_MAX);
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      state_s     = state_r;
      hold_cnt_s  = hold_cnt_r;
      flush_cnt_s = flush_cnt_r;
      case (state_r)
         ST_RESET_WAIT: begin
            if (hold_cnt_r == {HW{1'b0}}) state_s = ST_RUN;
            else                          hold_cnt_s = hold_cnt_r - HW'(1'b1);
         end
         ST_RUN, ST_HAZARD, ST_STALL: begin
            if (i_change_pc) begin
               state_s     = ST_FLUSH;
               flush_cnt_s = FLUSH_INIT;
            end else if (stall_req_s) begin
               state_s = ST_STALL;
            end else if (hazard_s) begin
               state_s = ST_HAZARD;
            end else begin
               state_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (i_change_pc)                      flush_cnt_s = FLUSH_INIT;
            else if (flush_cnt_r == {FW{1'b0}})   state_s = stall_req_s ? ST_STALL : ST_RUN;
            else                                  flush_cnt_s = flush_cnt_r - FW'(1'b1);
         end
         default: state_s = ST_RESET_WAIT;
      endcase

      // Consecutive stall cycles, including the RUN cycle that requested the stall.
      if (state_s != ST_STALL)         stall_cnt_s = {SW{1'b0}};
      else if (stall_cnt_r == STALL_MAX) stall_cnt_s = stall_cnt_r;
      else                             stall_cnt_s = stall_cnt_r + SW'(1'b1);
   end

   // Per-state control outputs.
   always_comb begin
      alu_ce_s    = 1'b0;
      dec_stall_s = 1'b1;
      alu_stall_s = stall_req_s;
      case (state_r)
         ST_RESET_WAIT: begin
            alu_stall_s = 1'b0;
         end
         ST_RUN: begin
            alu_ce_s    = i_dec_valid & ~hazard_s & ~stall_req_s & ~i_change_pc;
            dec_stall_s = hazard_s | stall_req_s;
         end
         ST_HAZARD, ST_FLUSH: begin
            dec_stall_s = 1'b0;
         end
         ST_STALL: begin
            dec_stall_s = 1'b1;
         end
         default: begin
            alu_stall_s = 1'b0;
         end
      endcase
   end

   assign o_alu_ce    = alu_ce_s;
   assign o_alu_stall = alu_stall_s;
   assign o_dec_stall = dec_stall_s;
   assign o_alu_flush = flush_r;
   assign o_state     = state_r;
   assign o_timeout   = timeout_r;

`ifdef ALU_STAGE_CTRL_PERF_EN
   logic [31:0] perf_issued_r, perf_bubbles_r;
   logic        bubble_s;

   assign bubble_s = (state_r == ST_HAZARD) | (state_r == ST_FLUSH) | (state_r == ST_STALL);

   // Free-running wrapping performance counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         perf_issued_r  <= 32'd0;
         perf_bubbles_r <= 32'd0;
      end else begin
         if (alu_ce_s) perf_issued_r <= perf_issued_r + 32'd1;
         else          perf_issued_r <= perf_issued_r;
         if (bubble_s) perf_bubbles_r <= perf_bubbles_r + 32'd1;
         else          perf_bubbles_r <= perf_bubbles_r;
      end
   end

   assign o_perf_issued  = perf_issued_r;
   assign o_perf_bubbles = perf_bubbles_r;
`else
   assign o_perf_issued  = 32'd0;
   assign o_perf_bubbles = 32'd0;
`endif

endmodule

// File: doc/alu_stage_ctrl.md
Name: alu_stage_ctrl

Overview:
Pipeline controller for the execute (ALU) stage of the rv32i core. It generates the ALU stage's clock-enable, stall and flush controls and the backpressure to decode. It arbitrates four conditions:
- post-reset hold
- branch/jump flush
- downstream (memory) stall, with a stall watchdog
- load-use hazard bubble insertion

It sits between decode, the ALU stage and the memory-access stage.

Parameters:
RST_HOLD, 2, cycles o_alu_ce is held low after reset release (>=1)
FLUSH_CYCLES, 2, cycles o_alu_flush stays asserted per pc change (>=1)
STALL_TIMEOUT, 1024, consecutive stall cycles before o_timeout sets (>=2)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_dec_valid  in  1  decode presents a valid instruction
i_dec_rs1_addr  in  5  rs1 of instruction in decode
i_dec_rs2_addr  in  5  rs2 of instruction in decode
i_dec_uses_rs2  in  1  instruction in decode reads rs2
i_alu_rd_addr  in  5  rd of instruction in ALU stage (ALU o_rd_addr)
i_alu_wr_rd  in  1  ALU-stage instruction writes rd (ALU o_wr_rd)
i_alu_is_load  in  1  ALU-stage instruction is a load
i_change_pc  in  1  ALU requests pc change (ALU o_change_pc)
i_mem_stall  in  1  memory stage stall request
i_force_stall  in  1  external forced stall
o_alu_ce  out  1  ALU i_ce (combinational)
o_alu_stall  out  1  ALU i_stall (combinational)
o_alu_flush  out  1  ALU i_flush (registered)
o_dec_stall  out  1  hold decode (combinational)
o_state  out  3  current FSM state (registered)
o_timeout  out  1  sticky stall-watchdog flag (registered)
o_perf_issued  out  32  issued-instruction count (see Optional Feature)
o_perf_bubbles  out  32  bubble-cycle count (see Optional Feature)

Behaviour:
- Reset (async, i_rst_n=0):
  - state RESET_WAIT (0), hold counter = RST_HOLD-1, flush counter 0, stall counter 0.
  - o_alu_flush=0, o_timeout=0, perf counters 0.
- States and encoding: RESET_WAIT=0, RUN=1, HAZARD=2, FLUSH=3, STALL=4.
- hazard (combinational): i_dec_valid & i_alu_is_load & i_alu_wr_rd & (i_alu_rd_addr!=0) & (i_alu_rd_addr==i_dec_rs1_addr | (i_dec_uses_rs2 & i_alu_rd_addr==i_dec_rs2_addr)).
- stall_req = i_mem_stall | i_force_stall. o_alu_stall = stall_req in every state except RESET_WAIT, where it is 0.
- Transition priority (evaluated every edge, outside RESET_WAIT): i_change_pc > stall_req > hazard > RUN.
- RESET_WAIT:
  - o_alu_ce=0, o_dec_stall=1.
  - Counts down; at 0 goes to RUN.
  - i_change_pc and stall_req are ignored.
- RUN:
  - o_alu_ce = i_dec_valid & ~hazard & ~stall_req & ~i_change_pc.
  - o_dec_stall = hazard | stall_req.
  - Next state: i_change_pc -> FLUSH (counter=FLUSH_CYCLES-1); stall_req -> STALL; hazard -> HAZARD.
- HAZARD:
  - Exactly one bubble: o_alu_ce=0, o_dec_stall=0.
  - Hazard detection is masked in this state so the held ALU-stage rd cannot re-trigger.
  - Next state is RUN unless i_change_pc or stall_req applies.
- FLUSH:
  - o_alu_flush=1 (registered, so it is visible the cycle after entry), o_alu_ce=0, o_dec_stall=0.
  - Counter decrements; exits to RUN (or STALL if stall_req) when it is 0.
  - i_change_pc re-asserted in FLUSH reloads the counter to FLUSH_CYCLES-1.
- STALL:
  - o_alu_ce=0, o_dec_stall=1.
  - Stall counter increments and saturates at STALL_TIMEOUT; on reaching STALL_TIMEOUT, o_timeout is set and stays 1 until reset.
  - On stall_req=0: stall counter cleared, go to RUN.
  - i_change_pc while stalled goes to FLUSH; the stall counter is cleared.
- Simultaneous i_change_pc and hazard: flush wins and no bubble is inserted.
- Reset asserted mid-flush or mid-stall: immediate return to RESET_WAIT; o_alu_flush drops asynchronously.

Optional Feature:
ALU_STAGE_CTRL_PERF_EN
- Defined:
  - o_perf_issued increments on every cycle with o_alu_ce=1.
  - o_perf_bubbles increments on every cycle in HAZARD, FLUSH or STALL.
  - Both are 32-bit and wrap 0xFFFFFFFF -> 0.
- Undefined: both ports are tied to 0 and no counter flops exist. The port list is unchanged.

Test Plan:
- Reset release with RST_HOLD=2, i_dec_valid=1 -> o_alu_ce=0 and o_dec_stall=1 for 2 cycles, then o_alu_ce=1 and o_state=1.
- Load rd=5 in ALU stage (i_alu_is_load=1, i_alu_wr_rd=1), decode rs1=5 -> same cycle o_alu_ce=0 and o_dec_stall=1, next cycle o_state=2 and o_dec_stall=0, following cycle o_alu_ce=1. Repeat with rd=0 -> no bubble.
- i_change_pc pulse 1 cycle in RUN -> o_alu_flush=1 for exactly 2 cycles starting the next cycle. A second pulse during FLUSH extends the flush to 2 cycles after that pulse.
- i_mem_stall held 5 cycles -> o_alu_stall=1 and o_dec_stall=1 all 5 cycles, o_state=4, o_timeout stays 0. With STALL_TIMEOUT=8, holding 10 cycles -> o_timeout=1 from the 9th cycle and sticky after the stall releases.
- i_change_pc and hazard in the same cycle -> FLUSH entered, no HAZARD state visited.
- With ALU_STAGE_CTRL_PERF_EN: 10 issue cycles + 1 hazard + 2 flush cycles -> o_perf_issued=10, o_perf_bubbles=3. Preload o_perf_issued near 0xFFFFFFFF and confirm it wraps to 0.
